// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB request master: FSM state encoding,
// the default ACCESS-phase timeout and the timeout counter width helper.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Width needed to count up to the timeout limit; a disabled timeout (0)
  // still gets a one-bit counter so no zero-width vectors appear.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// APB3 bus bundle. The initiator drives address/control/write data; the
// completer returns read data, ready and slave error.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_req_master_timeout_cnt.sv
// Saturating ACCESS-phase wait counter. expired_o flags the cycle whose
// increment would bring the count up to LIMIT, so the FSM can leave ACCESS
// on exactly that cycle. LIMIT = 0 disables expiry entirely.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned      CNT_W   = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count enabled cycles and
  // stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (LIMIT == 0) begin : g_no_timeout
    assign expired_o = 1'b0;
  end else begin : g_timeout
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
    assign expired_o = enable_i && (cnt_q >= LAST);
  end

endmodule

// File: rtl/apb_req_master.sv
// Core-request to APB3 initiator bridge. One transfer at a time:
// IDLE (grant) -> SETUP -> ACCESS (wait for pready or timeout) -> RESP
// (one-cycle response strobe) -> IDLE.
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  APB_BUS.Master                    apb_master
);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_enable),
    .expired_o (cnt_expired)
  );

  // Next-state and datapath capture. pready is checked before the timeout
  // so a completion arriving on the expiry cycle is treated as normal.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = we_i ? wdata_i : '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_clear = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cnt_enable = !apb_master.pready;
        if (apb_master.pready) begin
          rdata_d = we_q ? '0 : apb_master.prdata;
          err_d   = apb_master.pslverr;
          state_d = RESP;
        end else if (cnt_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Grant is only possible in IDLE and is masked while reset is held.
  assign gnt_o    = (state_q == IDLE) && req_i && !rst_i;
  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_master.penable = (state_q == ACCESS);
  assign apb_master.paddr   = addr_q;
  assign apb_master.pwrite  = we_q;
  assign apb_master.pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed plus randomized bench for apb_req_master with a short timeout.
// Expected response cycle, data and error come from the transfer rules:
// a transfer with W wait states responds W+3 cycles after the grant unless
// W reaches the timeout, in which case it aborts after TIMEOUT ACCESS cycles.
module tb_apb_req_master;

  localparam int unsigned TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqI;
  logic        weI;
  logic [31:0] addrI;
  logic [31:0] wdataI;
  logic        gntO;
  logic        rvalidO;
  logic [31:0] rdataO;
  logic        errO;

  int checks = 0;
  int errors = 0;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apbIf ();

  apb_req_master #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i      (clock),
    .rst_i      (reset),
    .req_i      (reqI),
    .we_i       (weI),
    .addr_i     (addrI),
    .wdata_i    (wdataI),
    .gnt_o      (gntO),
    .rvalid_o   (rvalidO),
    .rdata_o    (rdataO),
    .err_o      (errO),
    .apb_master (apbIf)
  );

  // Free-running clock, rising edge at 5, 15, 25 ...
  always #5 clock = ~clock;

  // One comparison: counts it, and reports and counts a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one transfer from IDLE, acting as the APB completer, and checks the
  // bus and response against the transfer rules. Starts and ends just after
  // a falling edge with the DUT in IDLE.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits,
                               input logic [31:0] readData, input logic slvErr,
                               input logic holdReq);
    int          expCycle;
    logic        expErr;
    logic [31:0] expData;
    logic [31:0] expPwdata;
    logic        lastAccess;
    if (TIMEOUT != 0 && waits >= int'(TIMEOUT)) begin
      expCycle = 2 + int'(TIMEOUT);
      expErr   = 1'b1;
      expData  = 32'h0;
    end else begin
      expCycle = 3 + waits;
      expErr   = slvErr;
      expData  = isWrite ? 32'h0 : readData;
    end
    expPwdata = isWrite ? wdata : 32'h0;

    reqI   = 1'b1;
    weI    = isWrite;
    addrI  = addr;
    wdataI = wdata;
    #1;
    checkOutput("gnt_idle", gntO, 1'b1);

    for (int cyc = 1; cyc <= expCycle; cyc++) begin
      @(negedge clock);
      if (!holdReq) begin
        reqI   = 1'b0;
        weI    = ~isWrite;
        addrI  = $urandom;
        wdataI = $urandom;
      end
      #1;
      if (cyc < expCycle) begin
        checkOutput("gnt_busy", gntO, 1'b0);
        checkOutput("rvalid_early", rvalidO, 1'b0);
        checkOutput("psel", apbIf.psel, 1'b1);
        checkOutput("penable", apbIf.penable, cyc >= 2);
        checkOutput("paddr", apbIf.paddr, addr);
        checkOutput("pwrite", apbIf.pwrite, isWrite);
        checkOutput("pwdata", apbIf.pwdata, expPwdata);
        lastAccess    = (cyc >= 2) && (cyc - 2 == waits);
        apbIf.pready  = lastAccess;
        apbIf.prdata  = lastAccess ? readData : $urandom;
        apbIf.pslverr = lastAccess ? slvErr : 1'($urandom);
      end else begin
        checkOutput("rvalid", rvalidO, 1'b1);
        checkOutput("rdata", rdataO, expData);
        checkOutput("err", errO, expErr);
        checkOutput("psel_resp", apbIf.psel, 1'b0);
        checkOutput("penable_resp", apbIf.penable, 1'b0);
        checkOutput("gnt_resp", gntO, 1'b0);
        apbIf.pready  = 1'b0;
        apbIf.pslverr = 1'b0;
      end
    end

    @(negedge clock);
    #1;
    checkOutput("rvalid_one_cycle", rvalidO, 1'b0);
    checkOutput("rdata_hold", rdataO, expData);
    checkOutput("gnt_back_idle", gntO, holdReq);
    reqI = 1'b0;
  endtask

  initial begin
    reqI          = 1'b1;
    weI           = 1'b0;
    addrI         = 32'h0;
    wdataI        = 32'h0;
    apbIf.pready  = 1'b0;
    apbIf.prdata  = 32'h0;
    apbIf.pslverr = 1'b0;

    // Power-on reset, with a request already pending.
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_gnt", gntO, 1'b0);
    checkOutput("rst_rvalid", rvalidO, 1'b0);
    checkOutput("rst_err", errO, 1'b0);
    checkOutput("rst_rdata", rdataO, 32'h0);
    checkOutput("rst_psel", apbIf.psel, 1'b0);
    checkOutput("rst_penable", apbIf.penable, 1'b0);
    checkOutput("rst_pwrite", apbIf.pwrite, 1'b0);
    checkOutput("rst_paddr", apbIf.paddr, 32'h0);
    checkOutput("rst_pwdata", apbIf.pwdata, 32'h0);
    reqI = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    $display("[TB] reset released");

    // Zero-wait read.
    applyStimulus(1'b0, 32'h1A10_0000, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    // Write with three wait states (pready lands on the timeout cycle).
    applyStimulus(1'b1, 32'h1A10_1004, 32'h0000_00FF, 3, 32'h5555_AAAA, 1'b0, 1'b0);
    // Read completing on the exact timeout cycle.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
    // Read that never sees pready: aborts with error and zero data.
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 20, 32'h9999_9999, 1'b0, 1'b0);
    // Core keeps req_i high throughout; only the IDLE cycle may grant.
    applyStimulus(1'b0, 32'h0000_00C0, 32'h0, 1, 32'h0BAD_CAFE, 1'b1, 1'b1);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
                    $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
    end

    // Read with slave error, leaving err_o and rdata_o non-zero.
    applyStimulus(1'b0, 32'h2000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset while the next transfer sits in ACCESS.
    reqI  = 1'b1;
    weI   = 1'b0;
    addrI = 32'h3000_0000;
    #1;
    checkOutput("gnt_pre_rst", gntO, 1'b1);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("penable_pre_rst", apbIf.penable, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", gntO, 1'b0);
    checkOutput("mid_rst_rvalid", rvalidO, 1'b0);
    checkOutput("mid_rst_err", errO, 1'b0);
    checkOutput("mid_rst_rdata", rdataO, 32'h0);
    checkOutput("mid_rst_psel", apbIf.psel, 1'b0);
    checkOutput("mid_rst_penable", apbIf.penable, 1'b0);
    checkOutput("mid_rst_pwrite", apbIf.pwrite, 1'b0);
    checkOutput("mid_rst_paddr", apbIf.paddr, 32'h0);
    checkOutput("mid_rst_pwdata", apbIf.pwdata, 32'h0);
    apbIf.pready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      checkOutput("rst_held_rvalid", rvalidO, 1'b0);
      checkOutput("rst_held_psel", apbIf.psel, 1'b0);
    end
    @(negedge clock);
    reset        = 1'b0;
    apbIf.pready = 1'b0;
    reqI         = 1'b0;

    // First request right after release must be granted.
    applyStimulus(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
